// File: rtl/scan_chain_driver.sv
// Driving end of a single scan chain: loads stimulus MSB-first, unloads the previous
// response on the same shifts, and compares it against the expected vector.
module scan_chain_driver #(
  parameter int CHAIN_LEN = 14,
  parameter int CNT_W     = 4,
  parameter int PCNT_W    = 16
) (
  input  logic                 CK,
  input  logic                 RN,
  input  logic                 pat_valid,
  output logic                 pat_ready,
  input  logic [CHAIN_LEN-1:0] pat_in,
  input  logic [CHAIN_LEN-1:0] exp_in,
  input  logic                 clr,
  input  logic                 test_so,
  output logic                 test_si,
  output logic                 test_se,
  output logic                 resp_valid,
  output logic [CHAIN_LEN-1:0] resp_out,
  output logic                 mismatch,
  output logic                 fail,
  output logic [PCNT_W-1:0]    pat_cnt,
  output logic                 busy
);

  typedef enum logic [1:0] {IDLE, SHIFT, CAPTURE, FLUSH} state_t;

  state_t               r_state, w_state_next;
  logic [CNT_W-1:0]     r_cnt;
  // Pattern MSB goes straight to the test_si register on accept, so only N-1 bits are held.
  logic [CHAIN_LEN-2:0] r_sh;
  logic [CHAIN_LEN-1:0] r_exp_nxt, r_exp_cur, r_resp_out;
  logic                 r_have_prev, r_test_si, r_test_se;
  logic                 r_resp_valid, r_mismatch, r_fail;
  logic [PCNT_W-1:0]    r_pat_cnt;

  logic                 w_accept, w_shifting, w_last, w_cmp, w_mis;
  logic                 w_si_next, w_se_next;
  logic [CHAIN_LEN-1:0] w_sh_shift;

  assign pat_ready  = (r_state == IDLE) || (r_state == CAPTURE);
  assign busy       = (r_state != IDLE);
  assign test_si    = r_test_si;
  assign test_se    = r_test_se;
  assign resp_valid = r_resp_valid;
  assign resp_out   = r_resp_out;
  assign mismatch   = r_mismatch;
  assign fail       = r_fail;
  assign pat_cnt    = r_pat_cnt;

  always_comb begin
    w_state_next = r_state;
    w_accept     = pat_valid && pat_ready;
    w_shifting   = (r_state == SHIFT) || (r_state == FLUSH);
    w_last       = (r_cnt == CNT_W'(CHAIN_LEN - 1));
    w_sh_shift   = {r_sh, test_so};
    w_cmp        = w_shifting && w_last && r_have_prev;
    w_mis        = |(w_sh_shift ^ r_exp_cur);
    case (r_state)
      IDLE:    if (w_accept) w_state_next = SHIFT;
      SHIFT:   if (w_last) w_state_next = CAPTURE;
      CAPTURE: w_state_next = w_accept ? SHIFT : FLUSH;
      FLUSH:   if (w_last) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
    w_se_next = (w_state_next == SHIFT) || (w_state_next == FLUSH);
    w_si_next = 1'b0;
    if (w_state_next == SHIFT)
      w_si_next = w_accept ? pat_in[CHAIN_LEN-1] : w_sh_shift[CHAIN_LEN-1];
  end

  always_ff @(posedge CK) begin
    if (!RN) begin
      r_state      <= IDLE;
      r_cnt        <= '0;
      r_sh         <= '0;
      r_exp_nxt    <= '0;
      r_exp_cur    <= '0;
      r_have_prev  <= 1'b0;
      r_test_si    <= 1'b0;
      r_test_se    <= 1'b0;
      r_resp_valid <= 1'b0;
      r_resp_out   <= '0;
      r_mismatch   <= 1'b0;
      r_fail       <= 1'b0;
      r_pat_cnt    <= '0;
    end else begin
      r_state   <= w_state_next;
      r_test_si <= w_si_next;
      r_test_se <= w_se_next;

      if (w_accept) begin
        r_sh      <= pat_in[CHAIN_LEN-2:0];
        r_exp_nxt <= exp_in;
        r_cnt     <= '0;
      end else if (w_shifting) begin
        r_sh  <= w_sh_shift[CHAIN_LEN-2:0];
        r_cnt <= w_last ? '0 : r_cnt + CNT_W'(1);
      end

      // The expected vector for the pattern just loaded becomes current when its shift ends.
      if (w_shifting && w_last)
        r_exp_cur <= r_exp_nxt;

      if (r_state == CAPTURE)
        r_have_prev <= 1'b1;
      else if ((r_state == FLUSH) && w_last)
        r_have_prev <= 1'b0;

      r_resp_valid <= w_cmp;
      r_mismatch   <= w_cmp && w_mis;
      if (w_cmp)
        r_resp_out <= w_sh_shift;

      // A mismatch on the clearing edge survives the clear.
      if (clr) begin
        r_fail    <= w_cmp && w_mis;
        r_pat_cnt <= w_cmp ? PCNT_W'(1) : '0;
      end else begin
        r_fail <= r_fail || (w_cmp && w_mis);
        if (w_cmp && (r_pat_cnt != '1))
          r_pat_cnt <= r_pat_cnt + PCNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_scan_chain_driver.sv
// Bench for scan_chain_driver with a 14-flop chain model that captures ~Q.
module tb_scan_chain_driver;
  localparam int N = 14;

  logic         CK = 1'b0, RN = 1'b0, pat_valid = 1'b0, clr = 1'b0;
  logic [N-1:0] pat_in = '0, exp_in = '0;
  logic         test_so, test_si, test_se, resp_valid, mismatch, fail, busy, pat_ready;
  logic [N-1:0] resp_out;
  logic [15:0]  pat_cnt;

  scan_chain_driver #(.CHAIN_LEN(N), .CNT_W(4), .PCNT_W(16)) dut (
    .CK(CK), .RN(RN), .pat_valid(pat_valid), .pat_ready(pat_ready), .pat_in(pat_in),
    .exp_in(exp_in), .clr(clr), .test_so(test_so), .test_si(test_si), .test_se(test_se),
    .resp_valid(resp_valid), .resp_out(resp_out), .mismatch(mismatch), .fail(fail),
    .pat_cnt(pat_cnt), .busy(busy)
  );

  always #5 CK = ~CK;

  logic [N-1:0] chain = '0;
  assign test_so = chain[N-1];
  always @(posedge CK) begin
    if (test_se === 1'b1) chain <= {chain[N-2:0], test_si};
    else                  chain <= ~chain;
  end

  int cyc = 0;
  always @(posedge CK) cyc++;

  logic [N-1:0] q_resp[$];
  logic         q_mis[$];
  int           q_cyc[$];
  always @(negedge CK) begin
    if (resp_valid === 1'b1) begin
      q_resp.push_back(resp_out);
      q_mis.push_back(mismatch);
      q_cyc.push_back(cyc);
      $display("resp: cyc=%0d resp_out=%h mismatch=%0b", cyc, resp_out, mismatch);
    end
  end

  int n_chk = 0, n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cyc %0d)", name, act, req, cyc);
    end
  endtask

  task automatic offer(input logic [N-1:0] p, input logic [N-1:0] e, output int acc);
    int g = 0;
    pat_valid = 1'b1; pat_in = p; exp_in = e;
    while (pat_ready !== 1'b1 && g < 200) begin
      @(negedge CK); g++;
    end
    if (g >= 200) begin
      n_chk++; n_fail++;
      $display("FAIL offer_timeout: pat_ready never rose for pattern %h", p);
    end
    acc = cyc;
    $display("accept: cyc=%0d pat_in=%h exp_in=%h", cyc, p, e);
    @(negedge CK);
  endtask

  task automatic wait_idle();
    int g = 0;
    while (busy !== 1'b0 && g < 200) begin
      @(negedge CK); g++;
    end
    if (g >= 200) begin
      n_chk++; n_fail++;
      $display("FAIL idle_timeout: busy stuck at %0b", busy);
    end
    @(negedge CK);
  endtask

  // Checks 14 consecutive shift cycles; optionally raises pat_valid at cycle raise_at.
  task automatic check_phase(input logic [N-1:0] p, input bit flush, input int raise_at,
                             input logic [N-1:0] rp, input logic [N-1:0] re);
    for (int k = 0; k < N; k++) begin
      chk(flush ? "flush_se_si" : "shift_se_si", {30'd0, test_se, test_si},
          {30'd0, 1'b1, flush ? 1'b0 : p[N-1-k]});
      chk("shift_ready_low", {31'd0, pat_ready}, 32'd0);
      if (k == raise_at) begin
        pat_valid = 1'b1; pat_in = rp; exp_in = re;
      end
      @(negedge CK);
    end
  endtask

  typedef struct {
    logic [N-1:0] pat;
    logic [N-1:0] expv;
    logic [N-1:0] resp;
    logic         mis;
  } vec_t;

  vec_t tbl[4];
  int   acc_tbl[4];
  int   acc;

  initial begin
    tbl[0] = '{14'h2AAA, 14'h1555, 14'h1555, 1'b0};
    tbl[1] = '{14'h1555, 14'h2AAA, 14'h2AAA, 1'b0};
    tbl[2] = '{14'h1234, 14'h2DCB, 14'h2DCB, 1'b0};
    tbl[3] = '{14'h3C0F, 14'h03F0, 14'h03F0, 1'b0};

    // Reset state
    repeat (2) @(negedge CK);
    chk("rst_se_si", {30'd0, test_se, test_si}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_fail", {31'd0, fail}, 32'd0);
    chk("rst_pat_cnt", {16'd0, pat_cnt}, 32'd0);
    chk("rst_ready", {31'd0, pat_ready}, 32'd1);
    chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("rst_resp_out", {18'd0, resp_out}, 32'd0);
    RN = 1'b1;

    // Single pattern, stalled into FLUSH, new offer held during FLUSH
    offer(14'h0001, 14'h3FFE, acc);
    pat_valid = 1'b0;
    check_phase(14'h0001, 1'b0, -1, '0, '0);
    chk("cap_se_si", {30'd0, test_se, test_si}, 32'd0);
    chk("cap_ready", {31'd0, pat_ready}, 32'd1);
    chk("cap_no_resp", {31'd0, resp_valid}, 32'd0);
    @(negedge CK);
    check_phase('0, 1'b1, 3, 14'h2AAA, 14'h1555);
    chk("single_resp_valid", {31'd0, resp_valid}, 32'd1);
    chk("single_resp_out", {18'd0, resp_out}, 32'h3FFE);
    chk("single_mismatch", {31'd0, mismatch}, 32'd0);
    chk("idle_ready", {31'd0, pat_ready}, 32'd1);
    chk("idle_busy", {31'd0, busy}, 32'd0);
    chk("single_fail", {31'd0, fail}, 32'd0);
    chk("single_pat_cnt", {16'd0, pat_cnt}, 32'd1);
    @(negedge CK);
    pat_valid = 1'b0;
    chk("idle_accept_se_si", {30'd0, test_se, test_si}, 32'd3);
    wait_idle();
    chk("stall_resp_count", q_resp.size(), 32'd2);
    if (q_resp.size() == 2) begin
      chk("stall_resp0", {18'd0, q_resp[0]}, 32'h3FFE);
      chk("stall_resp1", {18'd0, q_resp[1]}, 32'h1555);
    end
    chk("stall_pat_cnt", {16'd0, pat_cnt}, 32'd2);

    // Back-to-back table
    clr = 1'b1; @(negedge CK); clr = 1'b0;
    chk("clr_pat_cnt", {16'd0, pat_cnt}, 32'd0);
    q_resp.delete(); q_mis.delete(); q_cyc.delete();
    for (int i = 0; i < 4; i++) offer(tbl[i].pat, tbl[i].expv, acc_tbl[i]);
    pat_valid = 1'b0;
    wait_idle();
    chk("tbl_resp_count", q_resp.size(), 32'd4);
    for (int i = 0; i < 4; i++) begin
      if (i > 0) chk("tbl_period", acc_tbl[i] - acc_tbl[i-1], 32'd15);
      if (i < q_resp.size()) begin
        chk("tbl_resp_out", {18'd0, q_resp[i]}, {18'd0, tbl[i].resp});
        chk("tbl_mismatch", {31'd0, q_mis[i]}, {31'd0, tbl[i].mis});
        chk("tbl_resp_cyc", q_cyc[i], (i < 3) ? acc_tbl[i+1] + 15 : acc_tbl[i] + 30);
      end
    end
    chk("tbl_fail", {31'd0, fail}, 32'd0);
    chk("tbl_pat_cnt", {16'd0, pat_cnt}, 32'd4);

    // Mismatch, sticky fail, clr
    q_resp.delete(); q_mis.delete(); q_cyc.delete();
    offer(14'h0000, 14'h0000, acc);
    offer(14'h3FFF, 14'h0000, acc);
    pat_valid = 1'b0;
    wait_idle();
    chk("mis_resp_count", q_resp.size(), 32'd2);
    if (q_resp.size() == 2) begin
      chk("mis_resp0", {18'd0, q_resp[0]}, 32'h3FFF);
      chk("mis_flag0", {31'd0, q_mis[0]}, 32'd1);
      chk("mis_resp1", {18'd0, q_resp[1]}, 32'h0000);
      chk("mis_flag1", {31'd0, q_mis[1]}, 32'd0);
    end
    repeat (3) @(negedge CK);
    chk("mis_fail_sticky", {31'd0, fail}, 32'd1);
    chk("mis_pat_cnt", {16'd0, pat_cnt}, 32'd6);
    clr = 1'b1; @(negedge CK); clr = 1'b0;
    chk("clr_fail", {31'd0, fail}, 32'd0);
    chk("clr_pat_cnt2", {16'd0, pat_cnt}, 32'd0);

    // clr on the same edge as a mismatch
    offer(14'h0001, 14'h3FFE, acc);
    pat_valid = 1'b0;
    wait_idle();
    chk("pre_coinc_pat_cnt", {16'd0, pat_cnt}, 32'd1);
    offer(14'h0000, 14'h0000, acc);
    pat_valid = 1'b0;
    repeat (28) @(negedge CK);
    clr = 1'b1; @(negedge CK); clr = 1'b0;
    chk("coinc_resp_valid", {31'd0, resp_valid}, 32'd1);
    chk("coinc_mismatch", {31'd0, mismatch}, 32'd1);
    chk("coinc_fail", {31'd0, fail}, 32'd1);
    chk("coinc_pat_cnt", {16'd0, pat_cnt}, 32'd1);
    @(negedge CK);

    // Reset in SHIFT cycle 5
    offer(14'h2AAA, 14'h1555, acc);
    pat_valid = 1'b0;
    repeat (5) @(negedge CK);
    RN = 1'b0; @(negedge CK); RN = 1'b1;
    chk("midrst_se_si", {30'd0, test_se, test_si}, 32'd0);
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_fail", {31'd0, fail}, 32'd0);
    chk("midrst_pat_cnt", {16'd0, pat_cnt}, 32'd0);
    chk("midrst_ready", {31'd0, pat_ready}, 32'd1);
    q_resp.delete(); q_mis.delete(); q_cyc.delete();
    repeat (40) @(negedge CK);
    chk("midrst_no_resp", q_resp.size(), 32'd0);
    offer(14'h0001, 14'h3FFE, acc);
    pat_valid = 1'b0;
    wait_idle();
    chk("postrst_resp_count", q_resp.size(), 32'd1);
    if (q_resp.size() == 1) chk("postrst_resp", {18'd0, q_resp[0]}, 32'h3FFE);
    chk("postrst_pat_cnt", {16'd0, pat_cnt}, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish (cyc %0d)", cyc);
    $fatal(1, "watchdog");
  end

endmodule
